// File: rtl/dff_bank_pkg.sv
// Shared encodings for the flip-flop bank arbiter: bank operations, FSM states
// and a helper for sizing requester-index fields.
package dff_bank_pkg;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_SET = 2'b01,
    OP_CLR = 2'b10,
    OP_RD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner finder: first set request bit scanning
// upward from ptr, wrapping modulo NREQ.
module rr_pick
  import dff_bank_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [PW-1:0]   win_idx
);

  logic [PW-1:0] cand;
  logic          found;

  // ptr is always a legal index, so one subtraction is enough to wrap.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= int'(NREQ)) s = s - int'(NREQ);
    return PW'(s);
  endfunction

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    win_oh  = '0;
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = wrap_idx(ptr, k);
      if (!found && req[cand]) begin
        win_oh[cand] = 1'b1;
        win_idx      = cand;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter/sequencer that is the sole driver of a shared WIDTH-bit
// D flip-flop bank: write, preset-all, clear-all and read, one op per 3 cycles.
module dff_bank_arbiter
  import dff_bank_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PW    = idx_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  R,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] wdata,
  input  logic [WIDTH-1:0]      bank_q,
  output logic [WIDTH-1:0]      bank_d,
  output logic                  bank_s_n,
  output logic                  bank_r_n,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy
);

  state_e           state, state_nxt;
  logic [PW-1:0]    ptr;
  logic [NREQ-1:0]  win_oh;
  logic [PW-1:0]    win_idx;
  op_e              win_op;
  logic [WIDTH-1:0] win_data;
  op_e              cur_op;
  logic [WIDTH-1:0] cur_data;
  logic             s_n_reg;
  logic             r_n_reg;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  // Winner's op and data, selected with constant slices from the one-hot.
  always_comb begin
    win_op   = OP_WR;
    win_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win_oh[i]) begin
        win_op   = op_e'(op[2*i +: 2]);
        win_data = wdata[WIDTH*i +: WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge R) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!R) state <= ST_IDLE;
    else    state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (|req) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: bank D recirculates Q except during GRANT.
  always_comb begin
    busy   = (state != ST_IDLE);
    bank_d = bank_q;
    if (state == ST_GRANT) begin
      unique case (cur_op)
        OP_WR:  bank_d = cur_data;
        OP_SET: bank_d = '1;
        OP_CLR: bank_d = '0;
        OP_RD:  bank_d = bank_q;
      endcase
    end
  end

  // Datapath: grant/ack, latched transaction, pointer and preset/clear strobes.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      ptr      <= '0;
      gnt      <= '0;
      ack      <= '0;
      rdata    <= '0;
      cur_op   <= OP_WR;
      cur_data <= '0;
      s_n_reg  <= 1'b1;
      r_n_reg  <= 1'b1;
    end else begin
      ack     <= '0;
      s_n_reg <= 1'b1;
      r_n_reg <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt      <= win_oh;
            cur_op   <= win_op;
            cur_data <= win_data;
            ptr      <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            s_n_reg  <= (win_op != OP_SET);
            r_n_reg  <= (win_op != OP_CLR);
          end
        end
        ST_GRANT: begin
          gnt <= '0;
          ack <= gnt;
          unique case (cur_op)
            OP_WR:  rdata <= cur_data;
            OP_SET: rdata <= '1;
            OP_CLR: rdata <= '0;
            OP_RD:  rdata <= bank_q;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Controller reset also clears the bank; both lines are flop or single AND.
  assign bank_s_n = s_n_reg;
  assign bank_r_n = R & r_n_reg;

  // Simultaneous preset and clear on the bank is undefined.
  a_no_set_and_clr: assert property (@(posedge clk) disable iff (!R) (s_n_reg || r_n_reg));

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench: behavioural flip-flop bank plus a transaction-level
// reference model (round-robin scan over a request array, bank as a plain value).
module tb_dff_bank_arbiter;
  import dff_bank_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  R;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] wdata;
  logic [WIDTH-1:0]      bank_q, bank_d, rdata;
  logic                  bank_s_n, bank_r_n, busy;
  logic [NREQ-1:0]       gnt, ack;

  int               n_checks = 0;
  int               n_err    = 0;
  int               mptr     = 0;
  logic [WIDTH-1:0] mbank    = '0;

  always #5 clk = ~clk;

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .R        (R),
    .req      (req),
    .op       (op),
    .wdata    (wdata),
    .bank_q   (bank_q),
    .bank_d   (bank_d),
    .bank_s_n (bank_s_n),
    .bank_r_n (bank_r_n),
    .gnt      (gnt),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy)
  );

  // Flip-flop bank with asynchronous active-low preset and clear.
  always @(posedge clk or negedge bank_s_n or negedge bank_r_n) begin
    if (!bank_r_n)      bank_q <= '0;
    else if (!bank_s_n) bank_q <= '1;
    else                bank_q <= bank_d;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (mptr + k) % NREQ;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [1:0] o, input logic [WIDTH-1:0] d);
    req[i]                  = 1'b1;
    op[2*i +: 2]            = o;
    wdata[WIDTH*i +: WIDTH] = d;
  endtask

  // Starts at a negedge with the DUT idle and at least one request pending;
  // returns at the negedge of the following IDLE cycle.
  task automatic run_txn(input bit drop, input bit scramble, output int w);
    logic [1:0]       o;
    logic [WIDTH-1:0] d, exp_rd, exp_bd;
    w = model_pick();
    if (w < 0) begin
      check("txn_req", 32'(|req), 32'd1);
      return;
    end
    o = op[2*w +: 2];
    d = wdata[WIDTH*w +: WIDTH];
    case (o)
      2'b00:   exp_bd = d;
      2'b01:   exp_bd = '1;
      2'b10:   exp_bd = '0;
      default: exp_bd = mbank;
    endcase

    @(posedge clk); @(negedge clk);  // GRANT
    check("grant_gnt",  32'(gnt), 32'(1 << w));
    check("grant_ack",  32'(ack), 32'd0);
    check("grant_busy", 32'(busy), 32'd1);
    check("grant_s_n",  32'(bank_s_n), 32'(o != 2'b01));
    check("grant_r_n",  32'(bank_r_n), 32'(o != 2'b10));
    check("grant_d",    32'(bank_d), 32'(exp_bd));
    if (scramble) begin
      op[2*w +: 2]            = ~o;
      wdata[WIDTH*w +: WIDTH] = ~d;
    end
    if (drop) req[w] = 1'b0;

    @(posedge clk); @(negedge clk);  // ACK
    case (o)
      2'b00:   begin mbank = d;  exp_rd = d;     end
      2'b01:   begin mbank = '1; exp_rd = '1;    end
      2'b10:   begin mbank = '0; exp_rd = '0;    end
      default: begin             exp_rd = mbank; end
    endcase
    mptr = (w + 1) % NREQ;
    check("ack_gnt",   32'(gnt), 32'd0);
    check("ack_ack",   32'(ack), 32'(1 << w));
    check("ack_rdata", 32'(rdata), 32'(exp_rd));
    check("ack_bank",  32'(bank_q), 32'(mbank));
    check("ack_s_n",   32'(bank_s_n), 32'd1);
    check("ack_r_n",   32'(bank_r_n), 32'd1);

    @(posedge clk); @(negedge clk);  // back in IDLE
    check("idle_ack",   32'(ack), 32'd0);
    check("idle_busy",  32'(busy), 32'd0);
    check("idle_rdata", 32'(rdata), 32'(exp_rd));
    check("idle_bank",  32'(bank_q), 32'(mbank));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    R = 1'b0; req = '0; op = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt",   32'(gnt), 32'd0);
    check("rst_ack",   32'(ack), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_s_n",   32'(bank_s_n), 32'd1);
    check("rst_r_n",   32'(bank_r_n), 32'd0);
    check("rst_bank",  32'(bank_q), 32'd0);
    R = 1'b1;
    @(negedge clk);
    check("rel_r_n",  32'(bank_r_n), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);

    // Single write.
    set_req(0, 2'b00, 8'hA5);
    run_txn(1'b0, 1'b0, w);
    req[0] = 1'b0;

    // Preset via requester 2, then clear via requester 3.
    set_req(2, 2'b01, 8'h12);
    run_txn(1'b0, 1'b0, w);
    req[2] = 1'b0;
    check("preset_bank", 32'(bank_q), 32'hFF);
    set_req(3, 2'b10, 8'h34);
    run_txn(1'b0, 1'b0, w);
    req[3] = 1'b0;
    check("clear_bank", 32'(bank_q), 32'h00);

    // Fairness: all requesters reading, held high throughout.
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b11, WIDTH'($urandom));
    for (int i = 0; i < 5; i++) begin
      run_txn(1'b0, 1'b0, w);
      check("rr_order", 32'(w), 32'(i % NREQ));
    end
    req = '0;

    // Hold for 10 idle cycles, then read back.
    set_req(1, 2'b00, 8'h3C);
    run_txn(1'b0, 1'b0, w);
    req[1] = 1'b0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      check("hold_bank", 32'(bank_q), 32'h3C);
      check("hold_busy", 32'(busy), 32'd0);
    end
    set_req(1, 2'b11, 8'h00);
    run_txn(1'b0, 1'b0, w);
    req[1] = 1'b0;
    check("hold_read", 32'(rdata), 32'h3C);

    // Request dropped and inputs changed during GRANT.
    set_req(0, 2'b00, 8'h5A);
    run_txn(1'b1, 1'b1, w);
    check("drop_bank", 32'(bank_q), 32'h5A);

    // Reset in the middle of GRANT.
    req = '0;
    set_req(0, 2'b00, 8'h77);
    @(posedge clk); @(negedge clk);
    check("midrst_gnt_pre", 32'(gnt), 32'h1);
    #2 R = 1'b0;
    #1;
    check("midrst_bank", 32'(bank_q), 32'h00);
    check("midrst_gnt",  32'(gnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    req = '0;
    @(negedge clk);
    R = 1'b1;
    mptr = 0; mbank = '0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("midrst_noack", 32'(ack), 32'd0);
      check("midrst_idle",  32'(busy), 32'd0);
      check("midrst_hold",  32'(bank_q), 32'h00);
    end

    // Randomized traffic against the reference model.
    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(1, 0) == 1)
          set_req(i, 2'($urandom), WIDTH'($urandom));
      if (req == '0) begin
        @(posedge clk); @(negedge clk);
        check("rnd_idle_busy", 32'(busy), 32'd0);
        check("rnd_idle_bank", 32'(bank_q), 32'(mbank));
      end else begin
        run_txn($urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1, w);
        if (w >= 0 && req[w]) begin
          if ($urandom_range(3, 0) != 0) req[w] = 1'b0;
          else set_req(w, 2'($urandom), WIDTH'($urandom));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
